// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader and the control decoder.
// Holds the 6-bit mnemonic enumeration (42 supported codes), MIPS-I opcode
// and funct values, the loader FSM state type and small word-packing helpers.
package instr_encoder_loader_pkg;

  // Symbolic mnemonic codes; anything at or above NUM_MNEM is unsupported.
  typedef enum logic [5:0] {
    M_SLL = 6'd0, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR,
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_BLTZ, M_BGEZ, M_J, M_JAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ,
    M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
    M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW
  } mnem_e;

  localparam int unsigned NUM_MNEM = 42;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_LHU    = 6'b100101;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // REGIMM branches are distinguished by the rt field
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR} state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// instr_pack: purely combinational mnemonic + fields -> 32-bit MIPS word.
// Ports: mnem/rs/rt/rd/shamt/imm/target in; word out, valid=0 when the
// mnemonic is not one of the supported codes (word is then zero).
// Fields the architecture defines as zero for a given instruction are forced
// to zero here regardless of what the requester supplied.
module instr_pack
  import instr_encoder_loader_pkg::*;
(
  input  logic [5:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        valid
);

  always_comb begin
    word  = '0;
    valid = 1'b1;
    case (mnem)
      M_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      M_SRL:   word = r_word(5'd0, rt, rd, shamt, FN_SRL);
      M_SRA:   word = r_word(5'd0, rt, rd, shamt, FN_SRA);
      M_SLLV:  word = r_word(rs, rt, rd, 5'd0, FN_SLLV);
      M_SRLV:  word = r_word(rs, rt, rd, 5'd0, FN_SRLV);
      M_SRAV:  word = r_word(rs, rt, rd, 5'd0, FN_SRAV);
      M_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      M_JALR:  word = r_word(rs, 5'd0, rd, 5'd0, FN_JALR);
      M_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      M_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      M_SUB:   word = r_word(rs, rt, rd, 5'd0, FN_SUB);
      M_SUBU:  word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      M_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
      M_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
      M_XOR:   word = r_word(rs, rt, rd, 5'd0, FN_XOR);
      M_NOR:   word = r_word(rs, rt, rd, 5'd0, FN_NOR);
      M_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      M_SLTU:  word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
      M_BLTZ:  word = i_word(OP_REGIMM, rs, RT_BLTZ, imm);
      M_BGEZ:  word = i_word(OP_REGIMM, rs, RT_BGEZ, imm);
      M_J:     word = j_word(OP_J, target);
      M_JAL:   word = j_word(OP_JAL, target);
      M_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
      M_BNE:   word = i_word(OP_BNE, rs, rt, imm);
      M_BLEZ:  word = i_word(OP_BLEZ, rs, 5'd0, imm);
      M_BGTZ:  word = i_word(OP_BGTZ, rs, 5'd0, imm);
      M_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
      M_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
      M_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
      M_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm);
      M_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
      M_ORI:   word = i_word(OP_ORI, rs, rt, imm);
      M_XORI:  word = i_word(OP_XORI, rs, rt, imm);
      M_LUI:   word = i_word(OP_LUI, 5'd0, rt, imm);
      M_LB:    word = i_word(OP_LB, rs, rt, imm);
      M_LH:    word = i_word(OP_LH, rs, rt, imm);
      M_LW:    word = i_word(OP_LW, rs, rt, imm);
      M_LBU:   word = i_word(OP_LBU, rs, rt, imm);
      M_LHU:   word = i_word(OP_LHU, rs, rt, imm);
      M_SB:    word = i_word(OP_SB, rs, rt, imm);
      M_SH:    word = i_word(OP_SH, rs, rt, imm);
      M_SW:    word = i_word(OP_SW, rs, rt, imm);
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts symbolic instruction requests over
// valid/ready, encodes them into 32-bit MIPS words and writes them to
// consecutive IMEM word addresses starting at BASE_ADDR.
// Ports: clk, reset (sync, active-high), clear (sync rewind);
//   req_valid/req_ready handshake with req_mnem/rs/rt/rd/shamt/imm/target;
//   imem_wait in, imem_we/imem_addr/imem_wdata out;
//   prog_len (words written), full (last address written), err (sticky bad code).
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int IMEM_AW   = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [5:0]         req_mnem,
  input  logic [4:0]         req_rs,
  input  logic [4:0]         req_rt,
  input  logic [4:0]         req_rd,
  input  logic [4:0]         req_shamt,
  input  logic [15:0]        req_imm,
  input  logic [25:0]        req_target,
  input  logic               imem_wait,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [IMEM_AW:0]   prog_len,
  output logic               full,
  output logic               err
);

  localparam logic [IMEM_AW-1:0] BASE = IMEM_AW'(BASE_ADDR);
  localparam logic [IMEM_AW-1:0] LAST = '1;

  state_e      state, state_next;
  logic [5:0]  cap_mnem;
  logic [4:0]  cap_rs, cap_rt, cap_rd, cap_shamt;
  logic [15:0] cap_imm;
  logic [25:0] cap_target;
  logic [31:0] pack_word;
  logic        pack_valid;
  logic        accept;
  logic        write_done;

  instr_pack u_pack (
    .mnem   (cap_mnem),
    .rs     (cap_rs),
    .rt     (cap_rt),
    .rd     (cap_rd),
    .shamt  (cap_shamt),
    .imm    (cap_imm),
    .target (cap_target),
    .word   (pack_word),
    .valid  (pack_valid)
  );

  // reset/clear suppress ready and the write strobe in the same cycle so a
  // request cannot slip in and a pending write never reaches IMEM.
  assign req_ready  = (state == S_IDLE) && !full && !reset && !clear;
  assign imem_we    = (state == S_WR) && !reset && !clear;
  assign accept     = req_valid && req_ready;
  assign write_done = (state == S_WR) && !imem_wait;

  always_ff @(posedge clk) begin
    if (reset || clear) state <= S_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_ENC;
      S_ENC:   state_next = pack_valid ? S_WR : S_IDLE;
      S_WR:    if (!imem_wait) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cap_mnem   <= '0;
      cap_rs     <= '0;
      cap_rt     <= '0;
      cap_rd     <= '0;
      cap_shamt  <= '0;
      cap_imm    <= '0;
      cap_target <= '0;
      imem_wdata <= '0;
      imem_addr  <= BASE;
      prog_len   <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        cap_mnem   <= req_mnem;
        cap_rs     <= req_rs;
        cap_rt     <= req_rt;
        cap_rd     <= req_rd;
        cap_shamt  <= req_shamt;
        cap_imm    <= req_imm;
        cap_target <= req_target;
      end
      if (state == S_ENC) begin
        if (pack_valid) imem_wdata <= pack_word;
        else            err        <= 1'b1;
      end
      // The last address is never advanced past: the block goes full instead.
      if (write_done) begin
        prog_len <= prog_len + (IMEM_AW+1)'(1);
        if (imem_addr == LAST) full      <= 1'b1;
        else                   imem_addr <= imem_addr + IMEM_AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clear, req_valid, imem_wait;
  logic [5:0]  req_mnem;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [15:0] req_imm;
  logic [25:0] req_target;

  logic        req_ready, imem_we, full, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] prog_len;

  logic        sm_req_ready, sm_imem_we, sm_full, sm_err;
  logic [1:0]  sm_imem_addr;
  logic [31:0] sm_imem_wdata;
  logic [2:0]  sm_prog_len;

  always #5 clk = ~clk;

  instr_encoder_loader #(.IMEM_AW(10), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .imem_wait(imem_wait), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .prog_len(prog_len), .full(full), .err(err)
  );

  instr_encoder_loader #(.IMEM_AW(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .reset(reset), .clear(clear), .req_valid(req_valid), .req_ready(sm_req_ready),
    .req_mnem(req_mnem), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_target(req_target),
    .imem_wait(imem_wait), .imem_we(sm_imem_we), .imem_addr(sm_imem_addr),
    .imem_wdata(sm_imem_wdata), .prog_len(sm_prog_len), .full(sm_full), .err(sm_err)
  );

  typedef struct {
    logic [5:0]  mnem;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_word;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   compared = 0;
  int   mismatched = 0;
  int   small_we_count = 0;
  logic [9:0]  exp_addr = '0;
  logic [10:0] exp_len = '0;
  logic        exp_err = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit push);
    bit ready_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ready_seen = 1'b1;
        break;
      end
    end
    if (!ready_seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready_timeout: got req_ready=0 expected 1 within 30 cycles");
      return;
    end
    req_mnem = v.mnem; req_rs = v.rs; req_rt = v.rt; req_rd = v.rd;
    req_shamt = v.shamt; req_imm = v.imm; req_target = v.target;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (v.exp_valid) begin
      if (push) sb.push_back('{exp_addr, v.exp_word});
      exp_addr++;
      exp_len++;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic waitWe();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_we) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL we_timeout: got imem_we=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Scoreboard consumer: every completed write must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && !clear && imem_we && !imem_wait) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got write addr=%0d data=0x%08h expected none", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_addr", 32'(imem_addr), 32'(e.addr));
        checkOutput("wr_data", imem_wdata, e.data);
      end
    end
    if (!reset && !clear && sm_imem_we && !imem_wait) small_we_count++;
  end

  initial begin
    vec_t v;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [10:0] len0;
    int          we_cycles;

    reset = 1'b1; clear = 1'b0; req_valid = 1'b0; imem_wait = 1'b0;
    req_mnem = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0; req_imm = '0; req_target = '0;

    vecs[0]  = '{M_ADDU,  5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h00221821, 1'b1};
    vecs[1]  = '{M_LUI,   5'd7,  5'd4,  5'd0,  5'd0,  16'h1234, 26'h0,       32'h3C041234, 1'b1};
    vecs[2]  = '{M_SLL,   5'd9,  5'd5,  5'd6,  5'd2,  16'h0000, 26'h0,       32'h00053080, 1'b1};
    vecs[3]  = '{M_BGEZ,  5'd8,  5'd3,  5'd0,  5'd0,  16'hFFFE, 26'h0,       32'h0501FFFE, 1'b1};
    vecs[4]  = '{M_BLTZ,  5'd8,  5'd0,  5'd0,  5'd0,  16'hFFFE, 26'h0,       32'h0500FFFE, 1'b1};
    vecs[5]  = '{M_J,     5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000100, 32'h08000100, 1'b1};
    vecs[6]  = '{M_ADD,   5'd1,  5'd2,  5'd3,  5'd5,  16'h0000, 26'h0,       32'h00221820, 1'b1};
    vecs[7]  = '{M_SW,    5'd29, 5'd31, 5'd0,  5'd0,  16'h0008, 26'h0,       32'hAFBF0008, 1'b1};
    vecs[8]  = '{M_JR,    5'd31, 5'd3,  5'd4,  5'd5,  16'h0000, 26'h0,       32'h03E00008, 1'b1};
    vecs[9]  = '{M_JAL,   5'd0,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF, 1'b1};
    vecs[10] = '{M_SRAV,  5'd1,  5'd2,  5'd3,  5'd7,  16'h0000, 26'h0,       32'h00221807, 1'b1};
    vecs[11] = '{M_BLEZ,  5'd2,  5'd9,  5'd0,  5'd0,  16'h0010, 26'h0,       32'h18400010, 1'b1};
    vecs[12] = '{M_JALR,  5'd5,  5'd6,  5'd31, 5'd3,  16'h0000, 26'h0,       32'h00A0F809, 1'b1};
    vecs[13] = '{6'd63,   5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 26'h0,       32'h00000000, 1'b0};
    vecs[14] = '{M_ADDI,  5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF, 26'h0,       32'h2022FFFF, 1'b1};
    vecs[15] = '{M_SRL,   5'd0,  5'd3,  5'd4,  5'd31, 16'h0000, 26'h0,       32'h000327C2, 1'b1};

    // Reset state, including req_ready low during the reset cycle itself
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_we", 32'(imem_we), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_wdata", imem_wdata, 32'd0);
    checkOutput("rst_len", 32'(prog_len), 32'd0);
    checkOutput("rst_full_err", {30'd0, full, err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(req_ready), 32'd1);

    // First-transaction latency: accept edge N, strobe during N+2
    applyStimulus(vecs[0], 1'b1);
    @(negedge clk);
    checkOutput("lat_enc_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    checkOutput("lat_wr_we", 32'(imem_we), 32'd1);
    @(negedge clk);
    checkOutput("lat_len", 32'(prog_len), 32'd1);

    // Table of encodings, including an unsupported code mid-stream
    for (int i = 1; i < 16; i++) applyStimulus(vecs[i], 1'b1);
    waitDrain();
    checkOutput("tbl_len", 32'(prog_len), 32'(exp_len));
    checkOutput("tbl_addr", 32'(imem_addr), 32'(exp_addr));
    checkOutput("tbl_err", 32'(err), 32'(exp_err));

    // imem_wait held three cycles in WR: strobe held four cycles, one increment
    len0 = prog_len;
    imem_wait = 1'b1;
    applyStimulus(vecs[6], 1'b1);
    waitWe();
    a0 = imem_addr; d0 = imem_wdata; we_cycles = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (imem_we) we_cycles++;
      checkOutput("wait_addr_stable", 32'(imem_addr), 32'(a0));
      checkOutput("wait_data_stable", imem_wdata, d0);
    end
    @(posedge clk);
    #1 imem_wait = 1'b0;
    @(negedge clk);
    if (imem_we) we_cycles++;
    checkOutput("wait_addr_final", 32'(imem_addr), 32'(a0));
    @(negedge clk);
    checkOutput("wait_we_cycles", 32'(we_cycles), 32'd4);
    checkOutput("wait_we_dropped", 32'(imem_we), 32'd0);
    checkOutput("wait_len", 32'(prog_len), 32'(len0 + 11'd1));
    checkOutput("wait_addr_inc", 32'(imem_addr), 32'(a0 + 10'd1));

    // clear while a write is stalled: strobe drops, write discarded, all rewound
    imem_wait = 1'b1;
    applyStimulus(vecs[1], 1'b0);
    waitWe();
    @(posedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    checkOutput("clr_we_gated", 32'(imem_we), 32'd0);
    checkOutput("clr_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0; imem_wait = 1'b0;
    exp_addr = '0; exp_len = '0; exp_err = 1'b0;
    @(negedge clk);
    checkOutput("clr_addr", 32'(imem_addr), 32'd0);
    checkOutput("clr_len", 32'(prog_len), 32'd0);
    checkOutput("clr_flags", {30'd0, full, err}, 32'd0);
    checkOutput("clr_we", 32'(imem_we), 32'd0);

    // clear and req_valid together: request must not be taken
    @(posedge clk);
    #1 clear = 1'b1; req_valid = 1'b1; req_mnem = M_ADD;
    @(negedge clk);
    checkOutput("clr_valid_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0; req_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("clr_valid_len", 32'(prog_len), 32'd0);

    // Small instance: fill all four words, then a fifth request is ignored
    small_we_count = 0;
    for (int i = 0; i < 4; i++) begin
      v = vecs[i];
      applyStimulus(v, 1'b1);
      waitDrain();
      if (i == 2) checkOutput("sm_not_full_3", 32'(sm_full), 32'd0);
    end
    checkOutput("sm_full", 32'(sm_full), 32'd1);
    checkOutput("sm_ready_low", 32'(sm_req_ready), 32'd0);
    checkOutput("sm_addr_hold", 32'(sm_imem_addr), 32'd3);
    checkOutput("sm_len", 32'(sm_prog_len), 32'd4);
    checkOutput("sm_we_count", 32'(small_we_count), 32'd4);
    applyStimulus(vecs[5], 1'b1);
    waitDrain();
    checkOutput("sm_5th_ignored", 32'(small_we_count), 32'd4);
    checkOutput("sm_5th_len", 32'(sm_prog_len), 32'd4);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    exp_addr = '0; exp_len = '0;
    @(negedge clk);
    checkOutput("sm_clr_addr", 32'(sm_imem_addr), 32'd0);
    checkOutput("sm_clr_full", 32'(sm_full), 32'd0);
    checkOutput("sm_clr_ready", 32'(sm_req_ready), 32'd1);

    // reset during a stalled write behaves like clear
    imem_wait = 1'b1;
    applyStimulus(vecs[2], 1'b0);
    waitWe();
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_wr_we_gated", 32'(imem_we), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; imem_wait = 1'b0;
    @(negedge clk);
    checkOutput("rst_wr_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_wr_len", 32'(prog_len), 32'd0);
    checkOutput("rst_wr_we", 32'(imem_we), 32'd0);
    checkOutput("sb_leftover", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
